// File: rtl/spm_program_loader_if.sv
// rtl/spm_program_loader_if.sv - instruction-field stream and program-memory write bus of the SPM loader
interface spm_program_loader_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           in_opcode;
    logic [1:0]           in_src;
    logic [1:0]           in_dest;
    logic [7:0]           in_operand;
    logic                 in_last;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [7:0]           mem_data;
    logic                 mem_write;

    modport master (
        output in_valid, in_opcode, in_src, in_dest, in_operand, in_last,
        input  in_ready, mem_addr, mem_data, mem_write
    );

    modport slave (
        input  in_valid, in_opcode, in_src, in_dest, in_operand, in_last,
        output in_ready, mem_addr, mem_data, mem_write
    );
endinterface

// File: rtl/spm_program_loader.sv
// rtl/spm_program_loader.sv - encodes SPM instructions into memory words and writes them, holding the CPU in reset
// Optional checksum output enabled by LOADER_CHECKSUM_EN.
module spm_program_loader #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    spm_program_loader_if.slave bus,
    output logic busy,
    output logic done,
    output logic err,
    output logic cpu_rst_n
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [7:0] checksum
`endif
);
    // One extra counter bit so that stepping past the last address is visible instead of wrapping.
    localparam int CW = ADDR_SIZE + 1;
    localparam logic [CW-1:0] BASE  = CW'(BASE_ADDR);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_DEPTH);
    localparam logic [3:0]    OP_MAX = 4'd8;
    localparam logic [3:0]    OP_RD  = 4'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WR_INS,
        S_WR_ARG,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   addr;
    logic [3:0]      op_q;
    logic [1:0]      src_q;
    logic [1:0]      dest_q;
    logic [7:0]      operand_q;
    logic            last_q;

    logic            ready;
    logic            write;
    logic [ADDR_SIZE-1:0] waddr;
    logic [7:0]      wdata;
    logic            overflow;
    logic            two_word;
    logic            restart;
    logic [WORD_SIZE-1:0] ins_word;

    assign ins_word = {op_q, src_q, dest_q};
    assign overflow = (addr >= LIMIT);
    assign two_word = (op_q >= OP_RD);
    assign restart  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

    always_comb begin
        state_nx  = state;
        ready     = 1'b0;
        write     = 1'b0;
        waddr     = '0;
        wdata     = '0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        cpu_rst_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_ACCEPT;
            end
            S_ACCEPT: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (bus.in_valid) state_nx = (bus.in_opcode > OP_MAX) ? S_ERR : S_WR_INS;
            end
            S_WR_INS: begin
                busy = 1'b1;
                if (overflow) begin
                    state_nx = S_ERR;
                end else begin
                    write = 1'b1;
                    waddr = addr[ADDR_SIZE-1:0];
                    wdata = ins_word;
                    if (two_word)    state_nx = S_WR_ARG;
                    else if (last_q) state_nx = S_DONE;
                    else             state_nx = S_ACCEPT;
                end
            end
            S_WR_ARG: begin
                busy = 1'b1;
                if (overflow) begin
                    state_nx = S_ERR;
                end else begin
                    write    = 1'b1;
                    waddr    = addr[ADDR_SIZE-1:0];
                    wdata    = operand_q;
                    state_nx = last_q ? S_DONE : S_ACCEPT;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                cpu_rst_n = 1'b1;
                if (start) state_nx = S_ACCEPT;
            end
            S_ERR: begin
                err = 1'b1;
                if (start) state_nx = S_ACCEPT;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.in_ready  = ready;
    assign bus.mem_write = write;
    assign bus.mem_addr  = waddr;
    assign bus.mem_data  = wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            addr      <= BASE;
            op_q      <= '0;
            src_q     <= '0;
            dest_q    <= '0;
            operand_q <= '0;
            last_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (restart) begin
                addr <= BASE;
            end else if (write) begin
                addr <= addr + 1'b1;
            end
            if (ready && bus.in_valid) begin
                op_q      <= bus.in_opcode;
                src_q     <= bus.in_src;
                dest_q    <= bus.in_dest;
                operand_q <= bus.in_operand;
                last_q    <= bus.in_last;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum <= '0;
        end else if (restart) begin
            checksum <= '0;
        end else if (write) begin
            checksum <= checksum + wdata;
        end
    end
`endif
endmodule
